pwm_channel_scheduler: RTL and testbench



---
 rtl/pwm_channel_scheduler_pkg.sv | 18 +
 rtl/pwm_channel_scheduler_input_sync.sv | 23 ++
 rtl/pwm_channel_scheduler.sv | 159 +++++++++++++++
 tb/tb_pwm_channel_scheduler.sv | 303 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pwm_channel_scheduler_pkg.sv
// Shared types and helpers for the time-multiplexed PWM width scheduler.
// Holds the scheduler state encoding and the counter-width helper.
package pwm_channel_scheduler_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_SELECT    = 3'd1,
        ST_WAIT_LOW  = 3'd2,
        ST_WAIT_RISE = 3'd3,
        ST_MEASURE   = 3'd4
    } state_e;

    // Bits needed to hold every value 0..max_value (never less than one bit).
    function automatic int cnt_width(input int max_value);
        return (max_value < 1) ? 1 : $clog2(max_value + 1);
    endfunction

endpackage

// File: rtl/pwm_channel_scheduler_input_sync.sv
// Two-flop synchronizer for a vector of unrelated asynchronous inputs.
// Each bit is synchronized independently; no reset so sync_o is exactly async_i delayed two cycles.
module pwm_channel_scheduler_input_sync #(
    parameter int WIDTH = 1
) (
    input  logic             clock_i,
    input  logic [WIDTH-1:0] async_i,
    output logic [WIDTH-1:0] sync_o
);

    logic [WIDTH-1:0] meta_q;
    logic [WIDTH-1:0] sync_q;

    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
        always_ff @(posedge clock_i) begin
            meta_q[gi] <= async_i[gi];
            sync_q[gi] <= meta_q[gi];
        end
    end

    assign sync_o = sync_q;

endmodule

// File: rtl/pwm_channel_scheduler.sv
// Shares one pulse-width counter across NUM_CHANNELS PWM inputs in round-robin order
// and keeps a per-channel on/off decision with HIGH/LOW hysteresis.
module pwm_channel_scheduler
    import pwm_channel_scheduler_pkg::*;
#(
    parameter int NUM_CHANNELS       = 4,
    parameter int MAX_COUNTER_VALUE  = 2000,
    parameter int HIGH_COUNTER_VALUE = 1750,
    parameter int LOW_COUNTER_VALUE  = 1250,
    parameter int TIMEOUT_VALUE      = 40000
) (
    input  logic                                    clock_i,
    input  logic                                    reset_i,
    input  logic                                    enable_i,
    input  logic [NUM_CHANNELS-1:0]                 channel_mask_i,
    input  logic [NUM_CHANNELS-1:0]                 pwm_i,
    output logic [NUM_CHANNELS-1:0]                 outputs_o,
    output logic                                    valid_o,
    output logic                                    timeout_o,
    output logic [$clog2(NUM_CHANNELS)-1:0]         channel_o,
    output logic [cnt_width(MAX_COUNTER_VALUE)-1:0] width_o
);

    localparam int CHW = $clog2(NUM_CHANNELS);
    localparam int CW  = cnt_width(MAX_COUNTER_VALUE);
    localparam int TW  = cnt_width(TIMEOUT_VALUE);

    localparam logic [CW-1:0] MAX_C     = CW'(MAX_COUNTER_VALUE);
    localparam logic [CW-1:0] HIGH_C    = CW'(HIGH_COUNTER_VALUE);
    localparam logic [CW-1:0] LOW_C     = CW'(LOW_COUNTER_VALUE);
    localparam logic [CW-1:0] ONE_C     = CW'(1);
    localparam logic [TW-1:0] TO_LAST_C = TW'(TIMEOUT_VALUE - 1);

    logic [NUM_CHANNELS-1:0] pwm_sync;

    state_e                  state_q;
    logic [CHW-1:0]          ch_q;
    logic [CW-1:0]           cnt_q;
    logic [TW-1:0]           to_q;
    logic [NUM_CHANNELS-1:0] outputs_q;
    logic                    valid_q;
    logic                    timeout_q;
    logic [CHW-1:0]          channel_q;
    logic [CW-1:0]           width_q;

    logic [CHW-1:0]          next_ch_d;
    logic                    cur_sync_d;

    pwm_channel_scheduler_input_sync #(
        .WIDTH (NUM_CHANNELS)
    ) u_input_sync (
        .clock_i (clock_i),
        .async_i (pwm_i),
        .sync_o  (pwm_sync)
    );

    // First masked-in channel strictly after prev, wrapping; a lone channel picks itself.
    function automatic logic [CHW-1:0] next_channel(
        input logic [CHW-1:0]          prev,
        input logic [NUM_CHANNELS-1:0] mask
    );
        logic [CHW-1:0] pick;
        logic           found;
        int             idx;
        pick  = prev;
        found = 1'b0;
        for (int step = 1; step <= NUM_CHANNELS; step++) begin
            idx = (int'(prev) + step) % NUM_CHANNELS;
            if (!found && mask[CHW'(idx)]) begin
                pick  = CHW'(idx);
                found = 1'b1;
            end
        end
        return pick;
    endfunction

    always_comb begin
        next_ch_d  = next_channel(ch_q, channel_mask_i);
        cur_sync_d = pwm_sync[ch_q];
    end

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            state_q   <= ST_IDLE;
            ch_q      <= '0;
            cnt_q     <= '0;
            to_q      <= '0;
            outputs_q <= '0;
            valid_q   <= 1'b0;
            timeout_q <= 1'b0;
            channel_q <= '0;
            width_q   <= '0;
        end else begin
            valid_q   <= 1'b0;
            timeout_q <= 1'b0;
            // Dropping enable abandons whatever is in flight but keeps the rotation pointer.
            if (state_q != ST_IDLE && !enable_i) begin
                state_q <= ST_IDLE;
            end else begin
                case (state_q)
                    ST_IDLE: begin
                        if (enable_i && (channel_mask_i != '0)) begin
                            state_q <= ST_SELECT;
                        end
                    end
                    ST_SELECT: begin
                        if (channel_mask_i == '0) begin
                            state_q <= ST_IDLE;
                        end else begin
                            ch_q    <= next_ch_d;
                            to_q    <= '0;
                            state_q <= ST_WAIT_LOW;
                        end
                    end
                    ST_WAIT_LOW, ST_WAIT_RISE: begin
                        if (state_q == ST_WAIT_RISE && cur_sync_d) begin
                            cnt_q   <= ONE_C;
                            state_q <= ST_MEASURE;
                        end else if (to_q >= TO_LAST_C) begin
                            // A stuck line is reported as 0 % or 100 % duty.
                            timeout_q       <= 1'b1;
                            channel_q       <= ch_q;
                            outputs_q[ch_q] <= cur_sync_d;
                            state_q         <= ST_SELECT;
                        end else begin
                            to_q <= to_q + 1'b1;
                            if (state_q == ST_WAIT_LOW && !cur_sync_d) begin
                                state_q <= ST_WAIT_RISE;
                            end
                        end
                    end
                    ST_MEASURE: begin
                        if (cur_sync_d && (cnt_q < MAX_C)) begin
                            cnt_q <= cnt_q + 1'b1;
                        end else begin
                            width_q   <= cnt_q;
                            channel_q <= ch_q;
                            valid_q   <= 1'b1;
                            if (cnt_q > HIGH_C) begin
                                outputs_q[ch_q] <= 1'b1;
                            end else if (cnt_q < LOW_C) begin
                                outputs_q[ch_q] <= 1'b0;
                            end
                            state_q <= ST_SELECT;
                        end
                    end
                    default: state_q <= ST_IDLE;
                endcase
            end
        end
    end

    assign outputs_o = outputs_q;
    assign valid_o   = valid_q;
    assign timeout_o = timeout_q;
    assign channel_o = channel_q;
    assign width_o   = width_q;

endmodule

// File: tb/tb_pwm_channel_scheduler.sv
// Bench for pwm_channel_scheduler: directed scenarios plus randomized PWM traffic,
// all checked every cycle against a procedural model of the scheduling rules.
module tb_pwm_channel_scheduler;

    localparam int N     = 4;
    localparam int MAXV  = 20;
    localparam int HIGHV = 15;
    localparam int LOWV  = 10;
    localparam int TOV   = 50;

    logic         clk = 1'b0;
    logic         reset_i;
    logic         enable_i;
    logic [N-1:0] mask;
    logic [N-1:0] pwm = '0;
    logic [N-1:0] outputs;
    logic         valid;
    logic         timeout;
    logic [1:0]   chan;
    logic [4:0]   width;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;
    bit chk_en = 1'b0;

    // Stimulus generator state
    int hi_len [N];
    int lo_len [N];
    int pcnt   [N];
    bit stuck  [N];
    bit stuck_lvl [N];

    // Reference model state
    logic [N-1:0] s1 = '0, s2 = '0, m_sync = '0;
    logic [N-1:0] m_out = '0;
    bit m_valid = 1'b0, m_timeout = 1'b0;
    int m_chan = 0, m_width_o = 0, m_ptr = 0;
    int m_cnt = 0, m_waited = 0, m_phase = 0;
    bit m_seen_low = 1'b0, m_stop = 1'b0;

    pwm_channel_scheduler #(
        .NUM_CHANNELS       (N),
        .MAX_COUNTER_VALUE  (MAXV),
        .HIGH_COUNTER_VALUE (HIGHV),
        .LOW_COUNTER_VALUE  (LOWV),
        .TIMEOUT_VALUE      (TOV)
    ) dut (
        .clock_i        (clk),
        .reset_i        (reset_i),
        .enable_i       (enable_i),
        .channel_mask_i (mask),
        .pwm_i          (pwm),
        .outputs_o      (outputs),
        .valid_o        (valid),
        .timeout_o      (timeout),
        .channel_o      (chan),
        .width_o        (width)
    );

    always #5 clk = ~clk;

    // Per-channel waveform: hi_len high cycles, lo_len low cycles, or a stuck level.
    always @(negedge clk) begin
        for (int c = 0; c < N; c++) begin
            if (stuck[c]) begin
                pwm[c] = stuck_lvl[c];
                pcnt[c] = 1;
            end else if (pcnt[c] <= 1) begin
                if (pwm[c]) begin
                    pwm[c] = 1'b0;
                    pcnt[c] = lo_len[c];
                end else begin
                    pwm[c] = 1'b1;
                    pcnt[c] = hi_len[c];
                end
            end else begin
                pcnt[c] = pcnt[c] - 1;
            end
        end
    end

    // ---------------- reference model ----------------
    task automatic tick();
        @(posedge clk);
        m_sync = s2;
        s2 = s1;
        s1 = pwm;
        m_valid = 1'b0;
        m_timeout = 1'b0;
        if (reset_i) begin
            m_out = '0;
            m_chan = 0;
            m_width_o = 0;
            m_ptr = 0;
            m_phase = 0;
        end
    endtask

    initial begin : model
        forever begin
            tick();   // idle decision edge
            if (reset_i || !enable_i || mask == '0) continue;
            m_stop = 1'b0;
            while (!m_stop) begin
                tick();   // channel selection edge
                if (reset_i || !enable_i || mask == '0) break;
                for (int i = 1; i <= N; i++) begin
                    if (mask[(m_ptr + i) % N]) begin
                        m_ptr = (m_ptr + i) % N;
                        break;
                    end
                end
                m_waited = 0;
                m_seen_low = 1'b0;
                m_phase = 1;
                while (m_phase == 1) begin
                    tick();
                    if (reset_i || !enable_i) begin
                        m_phase = 0;
                        m_stop = 1'b1;
                    end else begin
                        m_waited = m_waited + 1;
                        if (m_seen_low && m_sync[m_ptr]) begin
                            m_phase = 2;
                            m_cnt = 1;
                        end else if (m_waited == TOV) begin
                            m_timeout = 1'b1;
                            m_chan = m_ptr;
                            m_out[m_ptr] = m_sync[m_ptr];
                            m_phase = 0;
                        end else if (!m_sync[m_ptr]) begin
                            m_seen_low = 1'b1;
                        end
                    end
                end
                while (m_phase == 2) begin
                    tick();
                    if (reset_i || !enable_i) begin
                        m_phase = 0;
                        m_stop = 1'b1;
                    end else if (m_sync[m_ptr] && m_cnt < MAXV) begin
                        m_cnt = m_cnt + 1;
                    end else begin
                        m_valid = 1'b1;
                        m_chan = m_ptr;
                        m_width_o = m_cnt;
                        if (m_cnt > HIGHV) m_out[m_ptr] = 1'b1;
                        else if (m_cnt < LOWV) m_out[m_ptr] = 1'b0;
                        m_phase = 0;
                    end
                end
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        cyc = cyc + 1;
        if (chk_en) begin
            checks = checks + 1;
            if (outputs !== m_out || valid !== m_valid || timeout !== m_timeout ||
                chan !== 2'(m_chan) || width !== 5'(m_width_o)) begin
                errors = errors + 1;
                $display("FAIL cycle %0d model_compare: dut out=%b v=%b t=%b ch=%0d w=%0d, expected out=%b v=%b t=%b ch=%0d w=%0d",
                         cyc, outputs, valid, timeout, chan, width,
                         m_out, m_valid, m_timeout, m_chan, m_width_o);
            end
        end
    end

    task automatic check(input string name, input int act, input int exp);
        checks = checks + 1;
        if (act != exp) begin
            errors = errors + 1;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // kind 0 = valid on channel ch, 1 = timeout on channel ch, 2 = any event
    task automatic wait_event(input int kind, input int ch, input int limit, input string name);
        int n;
        bit hit;
        n = 0;
        hit = 1'b0;
        while (!hit && n < limit) begin
            @(negedge clk);
            n = n + 1;
            case (kind)
                0: hit = valid && (int'(chan) == ch);
                1: hit = timeout && (int'(chan) == ch);
                default: hit = valid || timeout;
            endcase
        end
        if (!hit) begin
            checks = checks + 1;
            errors = errors + 1;
            $display("FAIL %s: no event within %0d cycles, expected channel %0d", name, limit, ch);
        end
    endtask

    initial begin : watchdog
        #5000000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    int exp_w [N] = '{18, 5, 12, 20};
    int hyst_h [6] = '{12, 8, 15, 16, 10, 9};
    int hyst_o [6] = '{1, 0, 0, 1, 1, 0};

    initial begin : main
        int n;
        reset_i = 1'b1;
        enable_i = 1'b0;
        mask = '0;
        for (int c = 0; c < N; c++) begin
            stuck[c] = 1'b0;
            stuck_lvl[c] = 1'b0;
            lo_len[c] = 7;
            pcnt[c] = 1;
        end
        hi_len[0] = 18; hi_len[1] = 5; hi_len[2] = 12; hi_len[3] = 25;
        repeat (4) @(negedge clk);
        chk_en = 1'b1;
        check("reset_outputs", int'(outputs), 0);
        check("reset_valid", int'(valid), 0);
        check("reset_timeout", int'(timeout), 0);
        check("reset_channel", int'(chan), 0);
        check("reset_width", int'(width), 0);

        // Basic rotation with fixed widths
        reset_i = 1'b0;
        enable_i = 1'b1;
        mask = 4'b1111;
        for (int c = 0; c < N; c++) begin
            wait_event(0, c, 600, "rot_wait");
            check("rot_width_dut", int'(width), exp_w[c]);
            check("rot_width_model", m_width_o, exp_w[c]);
        end
        check("rot_outputs", int'(outputs), 4'b1001);

        // Hysteresis on channel 0
        for (int i = 0; i < 6; i++) begin
            hi_len[0] = hyst_h[i];
            wait_event(0, 0, 1000, "hyst_wait");
            wait_event(0, 0, 1000, "hyst_wait");
            check("hyst_width", int'(width), hyst_h[i]);
            check("hyst_out0", int'(outputs[0]), hyst_o[i]);
        end

        // Channel 1 stuck high times out and rotation moves on to channel 2
        stuck[1] = 1'b1;
        stuck_lvl[1] = 1'b1;
        wait_event(1, 1, 2000, "to_wait");
        check("to_out1", int'(outputs[1]), 1);
        wait_event(2, 0, 600, "to_next");
        check("to_next_channel", int'(chan), 2);
        check("to_next_valid", int'(valid), 1);
        stuck[1] = 1'b0;

        // Reset in the middle of a measurement with all outputs high
        for (int c = 0; c < N; c++) hi_len[c] = 18;
        n = 0;
        while (outputs != 4'b1111 && n < 3000) begin
            @(negedge clk);
            n = n + 1;
        end
        check("rst_all_high", int'(outputs), 4'b1111);
        n = 0;
        while (m_phase != 2 && n < 500) begin
            @(negedge clk);
            n = n + 1;
        end
        reset_i = 1'b1;
        @(negedge clk);
        check("rst_outputs_cleared", int'(outputs), 0);
        reset_i = 1'b0;
        wait_event(2, 0, 600, "rst_first_event");
        check("rst_first_channel", int'(chan), 1);
        check("rst_first_valid", int'(valid), 1);

        // Randomized traffic: widths, masks, enable drops, stuck lines, resets
        for (int seg = 0; seg < 250; seg++) begin
            for (int c = 0; c < N; c++) begin
                hi_len[c] = $urandom_range(1, 25);
                lo_len[c] = $urandom_range(1, 30);
                stuck[c] = ($urandom_range(0, 15) == 0);
                stuck_lvl[c] = 1'($urandom_range(0, 1));
            end
            mask = ($urandom_range(0, 7) == 0) ? 4'h0 : 4'($urandom_range(1, 15));
            enable_i = ($urandom_range(0, 9) != 0);
            reset_i = ($urandom_range(0, 29) == 0);
            repeat ($urandom_range(20, 80)) @(negedge clk);
        end
        reset_i = 1'b0;
        repeat (10) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
